// File: rtl/inst_ram2.sv
// Instruction RAM with a byte-serial loader session (IDLE/LOAD/FLUSH) and a
// registered fetch port that is only served while the loader is idle.
module inst_ram2 #(
  parameter int             W     = 32,
  parameter int             DEPTH = 2048,
  parameter int             AW    = $clog2(DEPTH),
  parameter logic [W-1:0]   NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          fetch_req,
  input  logic [W-1:0]  pc,
  output logic          fetch_valid,
  output logic [W-1:0]  inst_data,
  output logic          fetch_fault,
  input  logic          ld_start,
  input  logic [W-1:0]  ld_base,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  input  logic          ld_end,
  output logic          busy,
  output logic [AW:0]   ld_words,
  output logic          ld_wrap
);

  localparam int NB = W / 8;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

  state_t         state, state_nx;
  logic [AW-1:0]  wp;
  logic [BW-1:0]  bidx;
  logic [W-1:0]   asm_q, word_nx, wdata;
  logic           accept, last_byte, flush_wr, we;
  logic           fetch_acc, fetch_bad;
  logic           fault_q, have_data;
  logic [W-1:0]   ram_q;
  logic [W-1:0]   mem [DEPTH];
  logic           unused_bits;

  assign unused_bits = ^ld_base;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ld_start) state_nx = LOAD;
      LOAD:    if (ld_end)   state_nx = FLUSH;
      FLUSH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ld_ready  = (state == LOAD) && !ld_end;
  assign busy      = (state != IDLE);
  assign accept    = ld_ready && ld_valid;
  assign last_byte = (bidx == BW'(NB - 1));
  assign flush_wr  = (state == FLUSH) && (bidx != '0);
  assign we        = (accept && last_byte) || flush_wr;
  assign wdata     = flush_wr ? asm_q : word_nx;

  always_comb begin
    word_nx = asm_q;
    word_nx[8*bidx +: 8] = ld_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wp       <= '0;
      bidx     <= '0;
      asm_q    <= '0;
      ld_words <= '0;
      ld_wrap  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && ld_start) begin
        wp       <= ld_base[AW+1:2];
        bidx     <= '0;
        asm_q    <= '0;
        ld_words <= '0;
        ld_wrap  <= 1'b0;
      end else if (accept) begin
        if (last_byte) begin
          // Assembly register is cleared per word so a flushed partial word
          // carries zeros in its unfilled lanes.
          asm_q    <= '0;
          bidx     <= '0;
          ld_words <= ld_words + (AW+1)'(1);
          if (wp == AW'(DEPTH - 1)) begin
            wp      <= '0;
            ld_wrap <= 1'b1;
          end else begin
            wp <= wp + AW'(1);
          end
        end else begin
          asm_q <= word_nx;
          bidx  <= bidx + BW'(1);
        end
      end else if (flush_wr) begin
        asm_q    <= '0;
        bidx     <= '0;
        ld_words <= ld_words + (AW+1)'(1);
      end
    end
  end

  assign fetch_acc = fetch_req && (state == IDLE);
  assign fetch_bad = (pc[1:0] != 2'b00)
                   || ({1'b0, pc[AW+1:2]} >= (AW+1)'(DEPTH))
                   || ((pc >> (AW + 2)) != '0);

  // Storage has no reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[wp] <= wdata;
    if (fetch_acc && !fetch_bad) ram_q <= mem[pc[AW+1:2]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_valid <= 1'b0;
      fault_q     <= 1'b0;
      have_data   <= 1'b0;
    end else begin
      fetch_valid <= fetch_acc;
      if (fetch_acc) begin
        fault_q   <= fetch_bad;
        have_data <= 1'b1;
      end
    end
  end

  // RAM output register is unreset; have_data masks it to zero after reset.
  assign inst_data   = !have_data ? '0 : (fault_q ? NOP : ram_q);
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_inst_ram2.sv
// Self-checking bench for inst_ram2: directed scenarios plus randomized load
// sessions and fetches compared against a word-array reference model.
module tb_inst_ram2;

  localparam int          W     = 32;
  localparam int          DEPTH = 2048;
  localparam int          AW    = 11;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk, rst_n;
  logic          fetch_req, fetch_valid, fetch_fault;
  logic [W-1:0]  pc, inst_data, ld_base;
  logic          ld_start, ld_valid, ld_ready, ld_end, busy, ld_wrap;
  logic [7:0]    ld_byte;
  logic [AW:0]   ld_words;

  inst_ram2 #(.W(W), .DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req(fetch_req), .pc(pc), .fetch_valid(fetch_valid),
    .inst_data(inst_data), .fetch_fault(fetch_fault),
    .ld_start(ld_start), .ld_base(ld_base), .ld_valid(ld_valid),
    .ld_byte(ld_byte), .ld_ready(ld_ready), .ld_end(ld_end),
    .busy(busy), .ld_words(ld_words), .ld_wrap(ld_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [31:0] mm    [DEPTH];
  bit          known [DEPTH];
  logic [7:0]  q[$];
  int          exp_words;
  bit          exp_wrap;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: bytes fill words little-endian from the base word index, modulo DEPTH.
  task automatic model_load(input logic [31:0] base);
    int unsigned start = (base >> 2) % DEPTH;
    int n  = q.size();
    int nw = (n + 3) / 4;
    for (int j = 0; j < nw; j++) begin
      logic [31:0] v = '0;
      for (int k = 0; k < 4; k++)
        if (4*j + k < n) v[8*k +: 8] = q[4*j + k];
      mm[(start + j) % DEPTH]    = v;
      known[(start + j) % DEPTH] = 1'b1;
    end
    exp_words = nw;
    exp_wrap  = (start + n / 4) >= DEPTH;
  endtask

  task automatic run_load(input logic [31:0] base, input bit gaps, input bit end_junk);
    ld_start = 1'b1; ld_base = base;
    tick();
    ld_start = 1'b0; ld_base = $urandom;
    foreach (q[i]) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          ld_valid = 1'b0; ld_byte = $urandom;
          tick();
        end
      end
      ld_valid = 1'b1; ld_byte = q[i];
      tests++;
      if (ld_ready !== 1'b1) begin
        fails++;
        $display("FAIL load_ready byte %0d: got %b want 1", i, ld_ready);
      end
      tick();
    end
    ld_valid = end_junk; ld_byte = $urandom; ld_end = 1'b1;
    #1;
    tests++;
    if (ld_ready !== 1'b0) begin
      fails++;
      $display("FAIL ready_at_end: got %b want 0", ld_ready);
    end
    tick();
    ld_end = 1'b0; ld_valid = 1'b0;
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_in_flush: got %b want 1", busy);
    end
    tick();
    model_load(base);
    tests++;
    if (busy !== 1'b0 || ld_words !== (AW+1)'(exp_words) || ld_wrap !== exp_wrap) begin
      fails++;
      $display("FAIL load_done base=%h: busy=%b words=%0d wrap=%b want busy=0 words=%0d wrap=%b",
               base, busy, ld_words, ld_wrap, exp_words, exp_wrap);
    end
  endtask

  task automatic fetch_chk(input logic [31:0] p, input string name);
    bit          bad   = (p[1:0] != 2'b00) || ((p >> 2) >= DEPTH);
    logic [31:0] exp_d = bad ? NOP : mm[p >> 2];
    fetch_req = 1'b1; pc = p;
    tick();
    fetch_req = 1'b0; pc = $urandom;
    tests++;
    if (fetch_valid !== 1'b1 || inst_data !== exp_d || fetch_fault !== bad) begin
      fails++;
      $display("FAIL %s pc=%h: valid=%b data=%h fault=%b want valid=1 data=%h fault=%b",
               name, p, fetch_valid, inst_data, fetch_fault, exp_d, bad);
    end
    tick();
    tests++;
    if (fetch_valid !== 1'b0 || inst_data !== exp_d || fetch_fault !== bad) begin
      fails++;
      $display("FAIL %s_hold pc=%h: valid=%b data=%h fault=%b want valid=0 data=%h fault=%b",
               name, p, fetch_valid, inst_data, fetch_fault, exp_d, bad);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_req = 1'b0; pc = '0; ld_start = 1'b0; ld_base = '0;
    ld_valid = 1'b0; ld_byte = '0; ld_end = 1'b0;
    #12;
    tests++;
    if (fetch_valid !== 1'b0 || inst_data !== '0 || fetch_fault !== 1'b0 || ld_ready !== 1'b0 ||
        busy !== 1'b0 || ld_words !== '0 || ld_wrap !== 1'b0) begin
      fails++;
      $display("FAIL reset_state: valid=%b data=%h fault=%b ready=%b busy=%b words=%0d wrap=%b want all 0",
               fetch_valid, inst_data, fetch_fault, ld_ready, busy, ld_words, ld_wrap);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_load_basic();
    q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(32'h10, 1'b0, 1'b1);
    tests++;
    if (ld_words !== (AW+1)'(2)) begin
      fails++;
      $display("FAIL basic_words: got %0d want 2", ld_words);
    end
    fetch_chk(32'h10, "basic_w4");
    fetch_chk(32'h14, "basic_w5");
  endtask

  task automatic test_partial();
    q = '{8'hAA, 8'hBB, 8'hCC};
    run_load(32'h0, 1'b0, 1'b0);
    tests++;
    if (ld_words !== (AW+1)'(1)) begin
      fails++;
      $display("FAIL partial_words: got %0d want 1", ld_words);
    end
    fetch_chk(32'h0, "partial_w0");
  endtask

  task automatic test_fetch_faults();
    fetch_chk(32'h14, "fetch_ok");
    fetch_chk(32'h15, "fetch_misaligned");
    fetch_chk(DEPTH * 4, "fetch_range");
    fetch_chk(32'h8000_0014, "fetch_highbits");
  endtask

  task automatic test_wrap();
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    run_load((DEPTH - 1) * 4, 1'b1, 1'b0);
    tests++;
    if (ld_wrap !== 1'b1) begin
      fails++;
      $display("FAIL wrap_flag: got %b want 1", ld_wrap);
    end
    fetch_chk((DEPTH - 1) * 4, "wrap_top");
    fetch_chk(32'h0, "wrap_zero");
  endtask

  task automatic test_contention();
    ld_start = 1'b1; ld_base = 32'h200;
    tick();
    ld_start = 1'b0; fetch_req = 1'b1; pc = 32'h14;
    q.delete();
    for (int i = 0; i < 4; i++) begin
      q.push_back(8'($urandom));
      ld_valid = 1'b1; ld_byte = q[i];
      tick();
      tests++;
      if (fetch_valid !== 1'b0) begin
        fails++;
        $display("FAIL contention_load cycle %0d: got %b want 0", i, fetch_valid);
      end
    end
    ld_valid = 1'b0; ld_end = 1'b1;
    tick();
    ld_end = 1'b0;
    tick();
    model_load(32'h200);
    tests++;
    if (fetch_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL contention_idle_edge: valid=%b busy=%b want 0 0", fetch_valid, busy);
    end
    tick();
    fetch_req = 1'b0;
    tests++;
    if (fetch_valid !== 1'b1 || inst_data !== mm[5] || fetch_fault !== 1'b0) begin
      fails++;
      $display("FAIL contention_served: valid=%b data=%h fault=%b want 1 %h 0",
               fetch_valid, inst_data, fetch_fault, mm[5]);
    end
    tick();
    fetch_chk(32'h200, "contention_loaded");
  endtask

  task automatic test_reset_midload();
    q.delete();
    for (int i = 0; i < 8; i++) q.push_back(8'($urandom));
    run_load(32'h100, 1'b0, 1'b0);
    fetch_chk(32'h104, "midload_prior");
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
    ld_start = 1'b1; ld_base = 32'h100;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ld_valid = 1'b1; ld_byte = q[i];
      tick();
    end
    ld_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (fetch_valid !== 1'b0 || inst_data !== '0 || fetch_fault !== 1'b0 || ld_ready !== 1'b0 ||
        busy !== 1'b0 || ld_words !== '0 || ld_wrap !== 1'b0) begin
      fails++;
      $display("FAIL midload_reset: valid=%b data=%h fault=%b ready=%b busy=%b words=%0d wrap=%b want all 0",
               fetch_valid, inst_data, fetch_fault, ld_ready, busy, ld_words, ld_wrap);
    end
    #2 rst_n = 1'b1;
    tick();
    // Only the completed first word of the aborted session reaches memory.
    mm[64] = {q[3], q[2], q[1], q[0]};
    fetch_chk(32'h100, "midload_done_word");
    fetch_chk(32'h104, "midload_discarded");
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      logic [31:0] base = ($urandom_range(0, 511) * 4) | $urandom_range(0, 3);
      int n = $urandom_range(1, 13);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      run_load(base, 1'b1, 1'($urandom_range(0, 1)));
      for (int f = 0; f < 3; f++) begin
        int unsigned a = ((base >> 2) + $urandom_range(0, (n - 1) / 4)) % DEPTH;
        fetch_chk(a * 4, "rand_fetch");
      end
      begin
        logic [31:0] p = $urandom;
        if (p[1:0] == 2'b00 && p < DEPTH * 4) p = p | 32'h1;
        fetch_chk(p, "rand_fault");
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mm[i] = '0;
      known[i] = 1'b0;
    end
    exp_words = 0;
    exp_wrap  = 1'b0;
    test_reset();
    test_load_basic();
    test_partial();
    test_fetch_faults();
    test_wrap();
    test_contention();
    test_reset_midload();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
